dcache_miss_handler: RTL and testbench
======================================

# dcache_miss_handler

Blocking, single-outstanding miss/store engine on the data-cache side of the dcache↔mem_ctrl link. It initiates requests toward `mem_ctrl` and consumes the responses. It accepts one load miss or write-through store from the dcache and drives the latency-insensitive request handshake (`valid`/`ready`). For reads it captures the latency-sensitive response, which has no ready, and returns the refill block to the dcache as a one-cycle fill pulse. A wait-timeout watchdog flags lost responses.

## Interface
Parameters:
- `VERBOSE`, 0, nonzero enables `$display` trace of state transitions (sim only).
- `MAX_WAIT`, 64, maximum cycles spent in WAIT before timeout; must be ≥2.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `miss_valid`  in  1  dcache presents a miss or store.
- `miss_ready`  out  1  handler can accept (IDLE only).
- `miss_type`  in  req_type_t  READ (load miss) or WRITE (store).
- `miss_addr`  in  addr_t  byte address.
- `miss_width`  in  req_width_t  store width.
- `miss_wdata`  in  block_data_t  store data.
- `req_valid`  out  1  request to mem_ctrl.
- `req_ready`  in  1  mem_ctrl accepts.
- `req_type`  out  req_type_t.
- `req_block_addr`  out  main_mem_block_addr_t  `miss_addr >> MAIN_MEM_BLOCK_OFFSET_WIDTH`.
- `req_block_data`  out  block_data_t  captured `miss_wdata`.
- `req_width`  out  req_width_t.
- `req_addr`  out  addr_t  captured `miss_addr`.
- `resp_valid`  in  1  read data valid, single cycle, no backpressure.
- `resp_block_data`  in  block_data_t.
- `fill_valid`  out  1  one-cycle refill pulse to dcache.
- `fill_block_addr`  out  main_mem_block_addr_t.
- `fill_block_data`  out  block_data_t.
- `wr_done`  out  1  one-cycle pulse: store accepted by mem_ctrl.
- `timeout_err`  out  1  sticky; set on WAIT timeout.
- `spurious_resp`  out  1  sticky; `resp_valid` seen outside WAIT.

## Operation
- FSM states: IDLE, REQ, WAIT, FILL.
- IDLE:
  - `miss_ready`=1.
  - On `miss_valid`, capture type, addr, width and wdata into registers, then go to REQ.
- REQ:
  - `req_valid`=1. All `req_*` fields come from the capture registers and stay stable until the handshake.
  - On `req_valid & req_ready`: for WRITE go to IDLE with `wr_done` pulsed the next cycle; for READ go to WAIT with the wait counter cleared.
- WAIT:
  - On `resp_valid`, register `resp_block_data` and go to FILL.
  - Otherwise the counter increments. When the counter reaches `MAX_WAIT-1` with no response, set `timeout_err` and go to IDLE with no fill.
- FILL:
  - `fill_valid`=1 for exactly one cycle, with `fill_block_addr` taken from the captured address and `fill_block_data` from the register.
  - Then go to IDLE.
- `resp_valid` in IDLE, REQ or FILL is ignored for data and sets `spurious_resp`.
- The counter is `$clog2(MAX_WAIT)` bits wide and never wraps; it saturates via the timeout transition.
- Capture registers update only on the IDLE accept. `req_*` data outputs hold their last value outside REQ; consumers must qualify them with `req_valid`.

## Timing
- Reset, with `rst` high at an edge, from any state, including mid-REQ or mid-WAIT:
  - State goes to IDLE and the counter to 0.
  - `miss_ready`=1 in the following cycle.
  - `req_valid`, `fill_valid`, `wr_done`, `timeout_err` and `spurious_resp` are 0.
  - Data outputs are 0.
  - An in-flight request is abandoned; a response arriving after reset counts as spurious.
- Store: accept at cycle 0; `req_valid` from cycle 1; handshake at cycle h≥1; `wr_done` at h+1. `miss_ready` is 1 at h+1, and a new miss can be accepted in that cycle.
- Load: accept at cycle 0; handshake at h; `resp_valid` at r≥h+1; `fill_valid` at r+1; `miss_ready` at r+2.
- `resp_valid` in the handshake cycle h itself counts as spurious. mem_ctrl guarantees a response latency of at least 1.
- Throughput: at most one request outstanding.

## Structure
- `req_type_t`, `req_width_t`, `addr_t`, `block_data_t`, `main_mem_block_addr_t` and `MAIN_MEM_BLOCK_OFFSET_WIDTH` come from the shared global definitions header.
- A new `dcache_mh_state_t` enum for the FSM states goes in the same header.
- Sub-module: `wait_timer`. It is a clearable, saturating up-counter that outputs an `expired` flag, parameterized by `MAX_WAIT`.

## Test plan
- Load miss at addr 0x0000_1040, `req_ready` high, `resp_valid` 3 cycles after the handshake with data 0xDEADBEEF… → `req_block_addr`=0x1040>>offset; `fill_valid` for one cycle with that data; `miss_ready` back two cycles after the response.
- Store, byte width, addr 0x2003, data 0xAB, `req_ready` held low for 5 cycles → `req_*` fields stable all 5 cycles; `wr_done` pulses exactly once, the cycle after the handshake.
- Two back-to-back stores with `miss_valid` held high → second accepted in the `wr_done` cycle; two handshakes; two `wr_done` pulses.
- Read with no response, `MAX_WAIT`=8 → `timeout_err` set after 8 WAIT cycles; no `fill_valid`; state IDLE.
- `resp_valid` pulsed while IDLE → `spurious_resp`=1, no fill. Then `rst` asserted mid-WAIT → all flags 0 and `miss_ready`=1 the next cycle; a late `resp_valid` then sets `spurious_resp` again.

Source files
------------

// File: rtl/dcache_miss_handler_pkg.sv
// Shared definitions for the dcache <-> mem_ctrl link: address/data types,
// request encodings and the miss-handler FSM state type.
package dcache_miss_handler_pkg;

    localparam int ADDR_WIDTH                  = 32;
    localparam int BLOCK_DATA_WIDTH            = 64;
    localparam int MAIN_MEM_BLOCK_OFFSET_WIDTH = 3;
    localparam int MAIN_MEM_BLOCK_ADDR_WIDTH   = ADDR_WIDTH - MAIN_MEM_BLOCK_OFFSET_WIDTH;

    typedef logic [ADDR_WIDTH-1:0]                addr_t;
    typedef logic [BLOCK_DATA_WIDTH-1:0]          block_data_t;
    typedef logic [MAIN_MEM_BLOCK_ADDR_WIDTH-1:0] main_mem_block_addr_t;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_t;

    typedef enum logic [1:0] {
        WIDTH_BYTE   = 2'd0,
        WIDTH_HALF   = 2'd1,
        WIDTH_WORD   = 2'd2,
        WIDTH_DOUBLE = 2'd3
    } req_width_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } dcache_mh_state_t;

    // Block address of a byte address (drops the in-block offset bits).
    function automatic main_mem_block_addr_t block_addr_of(input addr_t addr);
        return addr[ADDR_WIDTH-1:MAIN_MEM_BLOCK_OFFSET_WIDTH];
    endfunction

endpackage

// File: rtl/dcache_miss_handler_wait_timer.sv
// Clearable, saturating up-counter used as the response watchdog.
// expired is high once the count has reached MAX_WAIT-1; the counter then holds.
module wait_timer #(
    parameter int MAX_WAIT = 64
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int                CNT_W = $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    assign expired = (count_reg == LIMIT);

    // Next count: clear wins, otherwise count up until the limit and hold there.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && !expired) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/dcache_miss_handler.sv
// Blocking single-outstanding miss/store engine between dcache and mem_ctrl.
// Accepts one miss in IDLE, issues it with valid/ready, waits for the
// (unbackpressured) read response and returns it as a one-cycle fill.
module dcache_miss_handler
    import dcache_miss_handler_pkg::*;
#(
    parameter int VERBOSE  = 0,
    parameter int MAX_WAIT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_valid,
    output logic                 miss_ready,
    input  req_type_t            miss_type,
    input  addr_t                miss_addr,
    input  req_width_t           miss_width,
    input  block_data_t          miss_wdata,
    output logic                 req_valid,
    input  logic                 req_ready,
    output req_type_t            req_type,
    output main_mem_block_addr_t req_block_addr,
    output block_data_t          req_block_data,
    output req_width_t           req_width,
    output addr_t                req_addr,
    input  logic                 resp_valid,
    input  block_data_t          resp_block_data,
    output logic                 fill_valid,
    output main_mem_block_addr_t fill_block_addr,
    output block_data_t          fill_block_data,
    output logic                 wr_done,
    output logic                 timeout_err,
    output logic                 spurious_resp
);

    dcache_mh_state_t state_reg, state_next;

    req_type_t   cap_type_reg;
    addr_t       cap_addr_reg;
    req_width_t  cap_width_reg;
    block_data_t cap_wdata_reg;
    block_data_t fill_data_reg;
    logic        wr_done_reg;
    logic        timeout_err_reg;
    logic        spurious_reg;

    logic capture_en;
    logic fill_load;
    logic wr_done_next;
    logic timeout_set;
    logic timer_clear;
    logic timer_en;
    logic timer_expired;

    // Trace hooks are simulation-only and are kept out of the synthesizable body.
    if (VERBOSE != 0) begin : g_trace
    end

    // The watchdog only runs while waiting; every other state holds it at zero,
    // so it is already cleared on entry to WAIT.
    wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .clk    (clk),
        .srst   (rst),
        .clear  (timer_clear),
        .enable (timer_en),
        .expired(timer_expired)
    );

    // Next-state and control decode.
    always_comb begin
        state_next   = state_reg;
        capture_en   = 1'b0;
        fill_load    = 1'b0;
        wr_done_next = 1'b0;
        timeout_set  = 1'b0;
        timer_clear  = 1'b1;
        timer_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (miss_valid) begin
                    capture_en = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (req_ready) begin
                    if (cap_type_reg == REQ_WRITE) begin
                        wr_done_next = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                timer_clear = 1'b0;
                if (resp_valid) begin
                    // A response in the last permitted cycle still wins over the timeout.
                    fill_load  = 1'b1;
                    state_next = FILL;
                end else if (timer_expired) begin
                    timeout_set = 1'b1;
                    state_next  = IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            FILL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture registers: loaded only when a miss is accepted in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_type_reg  <= REQ_READ;
            cap_addr_reg  <= '0;
            cap_width_reg <= WIDTH_BYTE;
            cap_wdata_reg <= '0;
        end else if (capture_en) begin
            cap_type_reg  <= miss_type;
            cap_addr_reg  <= miss_addr;
            cap_width_reg <= miss_width;
            cap_wdata_reg <= miss_wdata;
        end
    end

    // Response data register, store-done pulse and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_data_reg   <= '0;
            wr_done_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
            spurious_reg    <= 1'b0;
        end else begin
            wr_done_reg <= wr_done_next;
            if (fill_load) begin
                fill_data_reg <= resp_block_data;
            end
            if (timeout_set) begin
                timeout_err_reg <= 1'b1;
            end
            if (resp_valid && (state_reg != WAIT)) begin
                spurious_reg <= 1'b1;
            end
        end
    end

    assign miss_ready      = (state_reg == IDLE);
    assign req_valid       = (state_reg == REQ);
    assign fill_valid      = (state_reg == FILL);
    assign req_type        = cap_type_reg;
    assign req_addr        = cap_addr_reg;
    assign req_width       = cap_width_reg;
    assign req_block_data  = cap_wdata_reg;
    assign req_block_addr  = block_addr_of(cap_addr_reg);
    assign fill_block_addr = block_addr_of(cap_addr_reg);
    assign fill_block_data = fill_data_reg;
    assign wr_done         = wr_done_reg;
    assign timeout_err     = timeout_err_reg;
    assign spurious_resp   = spurious_reg;

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Bench for dcache_miss_handler: transaction-level model of the handshake
// timing rules drives per-cycle expectations; a single negedge process compares.
module tb_dcache_miss_handler;
    import dcache_miss_handler_pkg::*;

    localparam int MW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 miss_valid;
    logic                 miss_ready;
    req_type_t            miss_type;
    addr_t                miss_addr;
    req_width_t           miss_width;
    block_data_t          miss_wdata;
    logic                 req_valid;
    logic                 req_ready;
    req_type_t            req_type;
    main_mem_block_addr_t req_block_addr;
    block_data_t          req_block_data;
    req_width_t           req_width;
    addr_t                req_addr;
    logic                 resp_valid;
    block_data_t          resp_block_data;
    logic                 fill_valid;
    main_mem_block_addr_t fill_block_addr;
    block_data_t          fill_block_data;
    logic                 wr_done;
    logic                 timeout_err;
    logic                 spurious_resp;

    always #5 clk = ~clk;

    dcache_miss_handler #(
        .VERBOSE (0),
        .MAX_WAIT(MW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .miss_valid     (miss_valid),
        .miss_ready     (miss_ready),
        .miss_type      (miss_type),
        .miss_addr      (miss_addr),
        .miss_width     (miss_width),
        .miss_wdata     (miss_wdata),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_type       (req_type),
        .req_block_addr (req_block_addr),
        .req_block_data (req_block_data),
        .req_width      (req_width),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_block_data(resp_block_data),
        .fill_valid     (fill_valid),
        .fill_block_addr(fill_block_addr),
        .fill_block_data(fill_block_data),
        .wr_done        (wr_done),
        .timeout_err    (timeout_err),
        .spurious_resp  (spurious_resp)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int txn_n = 0;
    int last_wait_cycles = 0;
    int n_hs = 0, n_wr_done = 0, n_fill = 0;
    bit check_en = 1'b0;

    // Expected control outputs for the current cycle.
    logic e_miss_ready, e_req_valid, e_fill_valid, e_wr_done, e_timeout, e_spur;
    // Model of the last accepted miss and the last delivered response.
    logic        m_type;
    addr_t       m_addr;
    logic [1:0]  m_width;
    block_data_t m_wdata;
    block_data_t m_fill;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            cmp("miss_ready", 64'(miss_ready), 64'(e_miss_ready));
            cmp("req_valid", 64'(req_valid), 64'(e_req_valid));
            cmp("fill_valid", 64'(fill_valid), 64'(e_fill_valid));
            cmp("wr_done", 64'(wr_done), 64'(e_wr_done));
            cmp("timeout_err", 64'(timeout_err), 64'(e_timeout));
            cmp("spurious_resp", 64'(spurious_resp), 64'(e_spur));
            cmp("req_type", 64'(req_type), 64'(m_type));
            cmp("req_addr", 64'(req_addr), 64'(m_addr));
            cmp("req_width", 64'(req_width), 64'(m_width));
            cmp("req_block_data", req_block_data, m_wdata);
            cmp("req_block_addr", 64'(req_block_addr), 64'(m_addr >> MAIN_MEM_BLOCK_OFFSET_WIDTH));
            cmp("fill_block_addr", 64'(fill_block_addr), 64'(m_addr >> MAIN_MEM_BLOCK_OFFSET_WIDTH));
            cmp("fill_block_data", fill_block_data, m_fill);
        end
    end

    // Event counters used by the directed literal checks.
    always @(negedge clk) begin
        if (req_valid === 1'b1 && req_ready === 1'b1) n_hs++;
        if (wr_done === 1'b1) n_wr_done++;
        if (fill_valid === 1'b1) n_fill++;
    end

    // Advance one cycle; was_wait says whether the cycle just ending was a WAIT cycle.
    task automatic tick(input bit was_wait);
        bit spur;
        spur = (resp_valid === 1'b1) && !was_wait;
        @(posedge clk);
        #1;
        cyc++;
        if (spur) e_spur = 1'b1;
        e_wr_done    = 1'b0;
        e_fill_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        miss_valid = 1'b0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
    endtask

    // Random don't-care traffic while the handler is busy.
    task automatic busy_inputs(input bit noise);
        miss_valid      = 1'($urandom_range(0, 1));
        miss_type       = req_type_t'($urandom_range(0, 1));
        miss_addr       = $urandom;
        miss_width      = req_width_t'($urandom_range(0, 3));
        miss_wdata      = {$urandom, $urandom};
        resp_valid      = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
        resp_block_data = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick(1'b1);
        rst          = 1'b0;
        e_miss_ready = 1'b1;
        e_req_valid  = 1'b0;
        e_fill_valid = 1'b0;
        e_wr_done    = 1'b0;
        e_timeout    = 1'b0;
        e_spur       = 1'b0;
        m_type       = 1'b0;
        m_addr       = '0;
        m_width      = 2'd0;
        m_wdata      = '0;
        m_fill       = '0;
        check_en     = 1'b1;
    endtask

    task automatic idle_cycles(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            busy_inputs(noise);
            miss_valid = 1'b0;
            req_ready  = 1'b0;
            tick(1'b0);
        end
        idle_inputs();
    endtask

    // One transaction, starting in a cycle where the handler is idle.
    // hs_wait: cycles req_ready stays low; rsp_lat: cycles from handshake to
    // response (>MW means no response); abort_k: leave mid-WAIT at that cycle.
    task automatic do_txn(input logic t, input addr_t a, input logic [1:0] w, input block_data_t d,
                          input int hs_wait, input int rsp_lat, input block_data_t rdata,
                          input bit noise, input int abort_k);
        txn_n++;
        $display("[TB] txn %0d %s addr=%h width=%0d hs_wait=%0d rsp_lat=%0d", txn_n,
                 t ? "WRITE" : "READ", a, w, hs_wait, rsp_lat);
        miss_valid      = 1'b1;
        miss_type       = req_type_t'(t);
        miss_addr       = a;
        miss_width      = req_width_t'(w);
        miss_wdata      = d;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_block_data = {$urandom, $urandom};
        tick(1'b0);
        m_type = t; m_addr = a; m_width = w; m_wdata = d;
        e_miss_ready = 1'b0;
        e_req_valid  = 1'b1;
        for (int i = 0; i <= hs_wait; i++) begin
            busy_inputs(noise);
            req_ready = (i == hs_wait);
            tick(1'b0);
        end
        req_ready   = 1'b0;
        e_req_valid = 1'b0;
        if (t == 1'b1) begin
            e_wr_done    = 1'b1;
            e_miss_ready = 1'b1;
            idle_inputs();
            return;
        end
        last_wait_cycles = 0;
        for (int k = 1; k <= MW; k++) begin
            if (abort_k != 0 && k == abort_k) return;
            busy_inputs(1'b0);
            req_ready = 1'b0;
            if (k == rsp_lat) begin
                resp_valid      = 1'b1;
                resp_block_data = rdata;
            end
            tick(1'b1);
            last_wait_cycles++;
            if (k == rsp_lat) begin
                m_fill       = rdata;
                e_fill_valid = 1'b1;
                busy_inputs(noise);
                miss_valid = 1'b0;
                req_ready  = 1'b0;
                tick(1'b0);
                e_miss_ready = 1'b1;
                idle_inputs();
                return;
            end
        end
        e_timeout    = 1'b1;
        e_miss_ready = 1'b1;
        idle_inputs();
    endtask

    initial begin
        int hs0, wd0, f0;
        rst = 1'b1;
        idle_inputs();
        miss_type       = REQ_READ;
        miss_addr       = '0;
        miss_width      = WIDTH_BYTE;
        miss_wdata      = '0;
        resp_block_data = '0;
        e_miss_ready = 1'b0; e_req_valid = 1'b0; e_fill_valid = 1'b0;
        e_wr_done = 1'b0; e_timeout = 1'b0; e_spur = 1'b0;
        m_type = 1'b0; m_addr = '0; m_width = 2'd0; m_wdata = '0; m_fill = '0;

        do_reset();
        cmp("reset_miss_ready", 64'(miss_ready), 64'd1);
        cmp("reset_req_addr", 64'(req_addr), 64'd0);

        // Load miss at 0x1040, response three cycles after the handshake.
        f0 = n_fill;
        do_txn(1'b0, 32'h0000_1040, 2'd3, 64'd0, 0, 3, 64'hDEADBEEF_0BADF00D, 1'b0, 0);
        cmp("load_block_addr", 64'(req_block_addr), 64'h208);
        cmp("load_fill_data", fill_block_data, 64'hDEADBEEF_0BADF00D);
        cmp("load_fill_count", 64'(n_fill - f0), 64'd1);
        idle_cycles(2, 1'b0);

        // Byte store at 0x2003 held off by req_ready for five cycles.
        wd0 = n_wr_done;
        do_txn(1'b1, 32'h0000_2003, 2'd0, 64'hAB, 5, 0, 64'd0, 1'b0, 0);
        cmp("store_req_addr", 64'(req_addr), 64'h2003);
        cmp("store_req_data", req_block_data, 64'hAB);
        idle_cycles(2, 1'b0);
        cmp("store_wr_done_count", 64'(n_wr_done - wd0), 64'd1);

        // Back-to-back stores: second accepted in the wr_done cycle.
        hs0 = n_hs; wd0 = n_wr_done;
        do_txn(1'b1, 32'h0000_3000, 2'd2, 64'h1111_2222, 0, 0, 64'd0, 1'b0, 0);
        do_txn(1'b1, 32'h0000_3008, 2'd2, 64'h3333_4444, 1, 0, 64'd0, 1'b0, 0);
        idle_cycles(1, 1'b0);
        cmp("b2b_handshakes", 64'(n_hs - hs0), 64'd2);
        cmp("b2b_wr_done", 64'(n_wr_done - wd0), 64'd2);

        // Read with no response times out after MAX_WAIT WAIT cycles.
        f0 = n_fill;
        do_txn(1'b0, 32'h0000_4000, 2'd3, 64'd0, 0, MW + 1, 64'd0, 1'b0, 0);
        cmp("timeout_wait_cycles", 64'(last_wait_cycles), 64'd8);
        cmp("timeout_flag", 64'(timeout_err), 64'd1);
        cmp("timeout_no_fill", 64'(n_fill - f0), 64'd0);
        idle_cycles(1, 1'b0);

        // Spurious response while idle.
        resp_valid = 1'b1;
        tick(1'b0);
        resp_valid = 1'b0;
        cmp("spurious_idle", 64'(spurious_resp), 64'd1);

        // Reset in the middle of WAIT, then a late response.
        do_txn(1'b0, 32'h0000_5040, 2'd3, 64'd0, 0, MW + 1, 64'd0, 1'b0, 3);
        do_reset();
        cmp("midwait_rst_ready", 64'(miss_ready), 64'd1);
        cmp("midwait_rst_timeout", 64'(timeout_err), 64'd0);
        cmp("midwait_rst_spur", 64'(spurious_resp), 64'd0);
        resp_valid = 1'b1;
        tick(1'b0);
        resp_valid = 1'b0;
        cmp("late_resp_spur", 64'(spurious_resp), 64'd1);

        // Randomized traffic with noise responses and occasional resets.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 29) == 0) do_reset();
            do_txn(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), {$urandom, $urandom},
                   $urandom_range(0, 4), $urandom_range(1, MW + 1), {$urandom, $urandom},
                   ($urandom_range(0, 3) == 0), 0);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3), ($urandom_range(0, 3) == 0));
        end
        idle_cycles(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
